alb_pipe: RTL and testbench

- Next-generation parametrised arithmetic/logic block.
- Widens the opcode set from 4 to 8 operations and adds a registered carry flag so multi-word arithmetic can be chained.
- Adds a 2-stage valid/ready pipeline with full back-pressure: one operation per cycle, in-order results with status flags.
- Sits between an operand source (register file or sequencer) and a result sink, both using valid/ready handshakes.

---
 rtl/alb_pipe.sv | 183 ++++++++++++++++++
 tb/tb_alb_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alb_pipe.sv
// alb_pipe: 8-opcode ALU behind a 2-stage valid/ready pipeline with a chained carry flag.
// Optional build macro ALB_PIPE_SAT_EN: signed saturation of ADD/SUB results on overflow.
module alb_pipe #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            i,
    input  logic                  ci,
    input  logic                  use_cf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] f,
    output logic                  co,
    output logic                  vo,
    output logic                  no,
    output logic                  zo
);

    localparam int W = DATA_WIDTH;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Stage 1 state
    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_a_q, s1_a_d;
    logic [W-1:0] s1_b_q, s1_b_d;
    logic [2:0]   s1_i_q, s1_i_d;
    logic         s1_cin_q, s1_cin_d;

    // Stage 2 state
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] f_q, f_d;
    logic         co_q, co_d;
    logic         vo_q, vo_d;
    logic         no_q, no_d;
    logic         zo_q, zo_d;

    logic         cf_q, cf_d;

    logic         s1_load;
    logic         s2_load;
    logic         cf_fwd;

    logic [W-1:0] b_op;
    logic [W:0]   sum;
    logic [W-1:0] alu_f;
    logic         alu_co;
    logic         alu_vo;

    assign in_ready  = !s1_valid_q || !out_valid_q || out_ready;
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);

    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign co        = co_q;
    assign vo        = vo_q;
    assign no        = no_q;
    assign zo        = zo_q;

    // Combinational ALU on the stage-1 beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_f  = '0;
        alu_co = 1'b0;
        alu_vo = 1'b0;
        b_op   = (s1_i_q == OP_SUB) ? ~s1_b_q : s1_b_q;
        sum    = {1'b0, s1_a_q} + {1'b0, b_op} + {{W{1'b0}}, s1_cin_q};
        case (s1_i_q)
            OP_AND:  alu_f = s1_a_q & s1_b_q;
            OP_ADD: begin
                alu_f  = sum[W-1:0];
                alu_co = sum[W];
                alu_vo = (s1_a_q[W-1] == s1_b_q[W-1]) && (sum[W-1] != s1_a_q[W-1]);
            end
            OP_OR:   alu_f = s1_a_q | s1_b_q;
            OP_SUB: begin
                alu_f  = sum[W-1:0];
                alu_co = sum[W];
                alu_vo = (s1_a_q[W-1] != s1_b_q[W-1]) && (sum[W-1] != s1_a_q[W-1]);
            end
            OP_XOR:  alu_f = s1_a_q ^ s1_b_q;
            OP_SHL: begin
                alu_f  = {s1_a_q[W-2:0], s1_cin_q};
                alu_co = s1_a_q[W-1];
            end
            OP_SHR: begin
                alu_f  = {s1_cin_q, s1_a_q[W-1:1]};
                alu_co = s1_a_q[0];
            end
            OP_PASS: alu_f = s1_a_q;
            default: alu_f = '0;
        endcase
`ifdef ALB_PIPE_SAT_EN
        if (alu_vo)
            alu_f = s1_a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    end

    // A beat accepted while an older beat leaves S1 must see that beat's carry, not the stale flag.
    assign cf_fwd = s2_load ? alu_co : cf_q;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_i_d      = s1_i_q;
        s1_cin_d    = s1_cin_q;
        out_valid_d = out_valid_q;
        f_d         = f_q;
        co_d        = co_q;
        vo_d        = vo_q;
        no_d        = no_q;
        zo_d        = zo_q;
        cf_d        = cf_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_i_d     = i;
            s1_cin_d   = use_cf ? cf_fwd : ci;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
            f_d         = alu_f;
            co_d        = alu_co;
            vo_d        = alu_vo;
            no_d        = alu_f[W-1];
            zo_d        = (alu_f == '0);
            cf_d        = alu_co;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            co_q        <= 1'b0;
            vo_q        <= 1'b0;
            no_q        <= 1'b0;
            zo_q        <= 1'b0;
            cf_q        <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            co_q        <= co_d;
            vo_q        <= vo_d;
            no_q        <= no_d;
            zo_q        <= zo_d;
            cf_q        <= cf_d;
        end
    end

    // NOTE: stage-1 payload is qualified by s1_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        s1_a_q   <= s1_a_d;
        s1_b_q   <= s1_b_d;
        s1_i_q   <= s1_i_d;
        s1_cin_q <= s1_cin_d;
    end

endmodule

// File: tb/tb_alb_pipe.sv
// Directed, table-driven bench for alb_pipe (DATA_WIDTH=8), with hand sequences for
// carry chaining, back-pressure and mid-stream reset. Honours ALB_PIPE_SAT_EN.
module tb_alb_pipe;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       ci;
        logic [7:0] f;
        logic       co;
        logic       vo;
        logic       no;
        logic       zo;
    } vec_t;

    typedef struct {
        logic [7:0] f;
        logic       co;
        logic       vo;
        logic       no;
        logic       zo;
        int         cyc;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       ci = 1'b0;
    logic       use_cf = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] f;
    logic       co, vo, no, zo;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    res_t q[$];
    vec_t vecs[12];

    alb_pipe #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .i        (op),
        .ci       (ci),
        .use_cf   (use_cf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .f        (f),
        .co       (co),
        .vo       (vo),
        .no       (no),
        .zo       (zo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every result consumed by the sink is logged with the cycle it left.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            q.push_back('{f: f, co: co, vo: vo, no: no, zo: zo, cyc: cyc});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the acceptance edge.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                        input logic tci, input logic tuse);
        int n;
        a = ta; b = tb; op = top; ci = tci; use_cf = tuse; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("accept timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string name);
        int budget;
        budget = 0;
        while (q.size() < n && budget < 50) begin
            budget++;
            @(posedge clk);
            #1;
        end
        check(name, q.size(), n);
    endtask

    task automatic check_res(input string name, input logic [7:0] ef, input logic eco,
                             input logic evo, input logic eno, input logic ezo);
        res_t r;
        if (q.size() == 0) begin
            check({name, " missing"}, 32'd0, 32'd1);
        end else begin
            r = q.pop_front();
            check({name, " f"},  {24'd0, r.f},  {24'd0, ef});
            check({name, " co"}, {31'd0, r.co}, {31'd0, eco});
            check({name, " vo"}, {31'd0, r.vo}, {31'd0, evo});
            check({name, " no"}, {31'd0, r.no}, {31'd0, eno});
            check({name, " zo"}, {31'd0, r.zo}, {31'd0, ezo});
        end
    endtask

    initial begin
        logic [7:0] bp_vals[4];
        int         k;
        int         first_cyc;
        logic       acc;

`ifdef ALB_PIPE_SAT_EN
        vecs[0]  = '{a: 8'h7F, b: 8'h01, op: OP_ADD,  ci: 1'b0, f: 8'h7F, co: 1'b0, vo: 1'b1, no: 1'b0, zo: 1'b0};
        vecs[9]  = '{a: 8'h80, b: 8'h01, op: OP_SUB,  ci: 1'b1, f: 8'h80, co: 1'b1, vo: 1'b1, no: 1'b1, zo: 1'b0};
`else
        vecs[0]  = '{a: 8'h7F, b: 8'h01, op: OP_ADD,  ci: 1'b0, f: 8'h80, co: 1'b0, vo: 1'b1, no: 1'b1, zo: 1'b0};
        vecs[9]  = '{a: 8'h80, b: 8'h01, op: OP_SUB,  ci: 1'b1, f: 8'h7F, co: 1'b1, vo: 1'b1, no: 1'b0, zo: 1'b0};
`endif
        vecs[1]  = '{a: 8'h00, b: 8'h01, op: OP_SUB,  ci: 1'b1, f: 8'hFF, co: 1'b0, vo: 1'b0, no: 1'b1, zo: 1'b0};
        vecs[2]  = '{a: 8'h05, b: 8'h05, op: OP_SUB,  ci: 1'b1, f: 8'h00, co: 1'b1, vo: 1'b0, no: 1'b0, zo: 1'b1};
        vecs[3]  = '{a: 8'h81, b: 8'hAA, op: OP_SHL,  ci: 1'b1, f: 8'h03, co: 1'b1, vo: 1'b0, no: 1'b0, zo: 1'b0};
        vecs[4]  = '{a: 8'h81, b: 8'h55, op: OP_SHR,  ci: 1'b0, f: 8'h40, co: 1'b1, vo: 1'b0, no: 1'b0, zo: 1'b0};
        vecs[5]  = '{a: 8'hF0, b: 8'h3C, op: OP_AND,  ci: 1'b1, f: 8'h30, co: 1'b0, vo: 1'b0, no: 1'b0, zo: 1'b0};
        vecs[6]  = '{a: 8'hF0, b: 8'h3C, op: OP_OR,   ci: 1'b1, f: 8'hFC, co: 1'b0, vo: 1'b0, no: 1'b1, zo: 1'b0};
        vecs[7]  = '{a: 8'hF0, b: 8'h3C, op: OP_XOR,  ci: 1'b1, f: 8'hCC, co: 1'b0, vo: 1'b0, no: 1'b1, zo: 1'b0};
        vecs[8]  = '{a: 8'hF0, b: 8'h3C, op: OP_PASS, ci: 1'b1, f: 8'hF0, co: 1'b0, vo: 1'b0, no: 1'b1, zo: 1'b0};
        vecs[10] = '{a: 8'hFF, b: 8'h01, op: OP_ADD,  ci: 1'b1, f: 8'h01, co: 1'b1, vo: 1'b0, no: 1'b0, zo: 1'b0};
        vecs[11] = '{a: 8'h00, b: 8'h00, op: OP_ADD,  ci: 1'b0, f: 8'h00, co: 1'b0, vo: 1'b0, no: 1'b0, zo: 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset f", {24'd0, f}, 32'd0);
        check("reset flags", {28'd0, co, vo, no, zo}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single-beat vectors; the first also checks latency.
        for (int v = 0; v < 12; v++) begin
            send(vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].ci, 1'b0);
            if (v == 0) begin
                @(negedge clk);
                check("latency edge+0 out_valid", {31'd0, out_valid}, 32'd0);
                @(negedge clk);
                check("latency edge+1 out_valid", {31'd0, out_valid}, 32'd1);
                @(posedge clk);
                #1;
            end
            wait_results(1, $sformatf("vec%0d count", v));
            check_res($sformatf("vec%0d", v), vecs[v].f, vecs[v].co, vecs[v].vo, vecs[v].no, vecs[v].zo);
        end

        // Chained 16-bit add 0x01FF + 0x0001, back-to-back.
        send(8'hFF, 8'h01, OP_ADD, 1'b0, 1'b0);
        send(8'h01, 8'h00, OP_ADD, 1'b0, 1'b1);
        wait_results(2, "chain count");
        check_res("chain lo", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        check_res("chain hi", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-pressure: 4 beats offered continuously with the sink stalled.
        bp_vals[0] = 8'h11; bp_vals[1] = 8'h22; bp_vals[2] = 8'h33; bp_vals[3] = 8'h44;
        out_ready = 1'b0;
        k = 0;
        a = bp_vals[0]; b = 8'h00; op = OP_PASS; ci = 1'b0; use_cf = 1'b0; in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            acc = in_ready;
            if (out_valid)
                check("stall f stable", {24'd0, f}, 32'h11);
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < 4) a = bp_vals[k];
            end
        end
        check("stall accepted", k, 2);
        @(negedge clk);
        check("stall in_ready", {31'd0, in_ready}, 32'd0);
        check("stall out_valid", {31'd0, out_valid}, 32'd1);
        check("stall nothing consumed", q.size(), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        while (k < 4) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < 4) a = bp_vals[k];
            end
        end
        in_valid = 1'b0;
        wait_results(4, "bp count");
        repeat (4) @(posedge clk);
        #1;
        check("bp no duplicates", q.size(), 4);
        first_cyc = (q.size() > 0) ? q[0].cyc : 0;
        for (int n = 0; n < 4; n++) begin
            if (q.size() > 0) begin
                check($sformatf("bp order %0d", n), {24'd0, q[0].f}, {24'd0, bp_vals[n]});
                check($sformatf("bp rate %0d", n), q[0].cyc - first_cyc, n);
                void'(q.pop_front());
            end else begin
                check($sformatf("bp missing %0d", n), 32'd0, 32'd1);
            end
        end

        // Reset with two carry-producing beats in flight.
        out_ready = 1'b0;
        send(8'hFF, 8'h01, OP_ADD, 1'b0, 1'b0);
        send(8'hFF, 8'h01, OP_ADD, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset f", {24'd0, f}, 32'd0);
        check("midreset flags", {28'd0, co, vo, no, zo}, 32'd0);
        check("midreset cf", {31'd0, dut.cf_q}, 32'd0);
        check("midreset in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h01, 8'h01, OP_ADD, 1'b1, 1'b1);
        wait_results(1, "post-reset count");
        repeat (4) @(posedge clk);
        #1;
        check("post-reset single result", q.size(), 1);
        check_res("post-reset add", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
